// File: rtl/rv_prefetch_unit.sv
// Decoupled rv32 instruction prefetch unit.
// Fetches sequential words over the I-bus, one transaction at a time, into a
// small FIFO. Each entry holds {pc, instruction}. A redirect flushes the FIFO
// and restarts fetch. An abandoned bus transaction is still allowed to finish
// (DRAIN) before fetching from the new target.

package rv_prefetch_pkg;
  typedef enum logic [1:0] {READ = 2'b00, WRITE = 2'b01} ttype_e;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} tsize_e;
endpackage

module rv_prefetch_unit
  import rv_prefetch_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ibus_breq,
  output logic                       ibus_bstart,
  output logic [31:0]                ibus_addr,
  output ttype_e                     ibus_ttype,
  output tsize_e                     ibus_tsize,
  output logic [31:0]                ibus_wdata,
  input  logic [31:0]                ibus_rdata,
  input  logic                       ibus_bdone,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DRAIN = 2'b10} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic          bstart_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q, level_after;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;

  // The low two bits of a redirect target are masked off so fetches stay word aligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign ibus_breq   = 1'b1;
  assign ibus_ttype  = READ;
  assign ibus_tsize  = WORD;
  assign ibus_wdata  = 32'h0;
  assign ibus_bstart = bstart_q;
  assign ibus_addr   = fetch_pc_q;

  assign level      = level_q;
  assign inst_valid = (level_q != '0);
  assign inst_pc    = mem_pc[rd_ptr_q];
  assign inst_data  = mem_data[rd_ptr_q];

  assign pop  = inst_valid & inst_ready;
  assign push = (state_q == BUSY) & ibus_bdone & ~redirect_valid;

  // Occupancy after this cycle's push and pop, ignoring any flush.
  always_comb begin
    level_after = level_q;
    if (push && !pop) begin
      level_after = level_q + LW'(1);
    end else if (!push && pop) begin
      level_after = level_q - LW'(1);
    end
  end

  // Fetch sequencing: choose next state and next fetch and pending addresses.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = BUSY;
        end else if (level_q < DEPTH_L) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ibus_bdone) begin
          if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            state_d    = BUSY;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (level_after < DEPTH_L) ? BUSY : IDLE;
          end
        end else if (redirect_valid) begin
          pending_pc_d = redirect_target;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pending_pc_d = redirect_target;
        end
        if (ibus_bdone) begin
          fetch_pc_d = redirect_valid ? redirect_target : pending_pc_q;
          state_d    = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; a bus transaction is active in every state except IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= INITIAL_PC;
      pending_pc_q <= INITIAL_PC;
      bstart_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      bstart_q     <= (state_d != IDLE);
    end
  end

  // FIFO pointers and occupancy. A redirect empties the queue regardless of push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q <= level_after;
    end
  end

  // FIFO storage. Contents do not need a reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= fetch_pc_q;
      mem_data[wr_ptr_q] <= ibus_rdata;
    end
  end

endmodule

// File: tb/tb_rv_prefetch_unit.sv
// Directed testbench for rv_prefetch_unit (INITIAL_PC=0x100, DEPTH=4).
// The bus slave returns ~addr as data. It either completes in the same cycle
// a transaction is seen (auto mode) or completes under manual control.

module tb_rv_prefetch_unit;
  import rv_prefetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ibus_breq;
  logic        ibus_bstart;
  logic [31:0] ibus_addr;
  ttype_e      ibus_ttype;
  tsize_e      ibus_tsize;
  logic [31:0] ibus_wdata;
  logic [31:0] ibus_rdata;
  logic        ibus_bdone;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  level;

  logic        auto_done;
  logic        man_done;
  int          total;
  int          bad;
  int          done_count;
  int          done_base;
  logic [31:0] last_done_addr;

  rv_prefetch_unit #(
    .INITIAL_PC (32'h0000_0100),
    .DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus_breq      (ibus_breq),
    .ibus_bstart    (ibus_bstart),
    .ibus_addr      (ibus_addr),
    .ibus_ttype     (ibus_ttype),
    .ibus_tsize     (ibus_tsize),
    .ibus_wdata     (ibus_wdata),
    .ibus_rdata     (ibus_rdata),
    .ibus_bdone     (ibus_bdone),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .level          (level)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus slave: the data word is the inverted address, and completion is automatic or manual.
  assign ibus_rdata = ~ibus_addr;
  assign ibus_bdone = auto_done ? ibus_bstart : man_done;

  // Count completed bus transactions and remember the most recent address.
  always @(posedge clk) begin
    if (rst_n && ibus_bstart && ibus_bdone) begin
      done_count     = done_count + 1;
      last_done_addr = ibus_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic au, input logic md);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    auto_done      = au;
    man_done       = md;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected)
    else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    done_count     = 0;
    done_base      = 0;
    last_done_addr = 32'h0;
    rst_n          = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    $display("[TB] reset state");
    checkOutput("rst_bstart", 32'(ibus_bstart), 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_addr", ibus_addr, 32'h100);
    checkOutput("breq", 32'(ibus_breq), 32'd1);
    checkOutput("ttype", 32'(ibus_ttype), 32'(READ));
    checkOutput("tsize", 32'(ibus_tsize), 32'(WORD));
    checkOutput("wdata", ibus_wdata, 32'h0);

    $display("[TB] sequential fetch, zero-wait slave");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("seq_bstart1", 32'(ibus_bstart), 32'd1);
    checkOutput("seq_addr1", ibus_addr, 32'h100);
    checkOutput("seq_valid1", 32'(inst_valid), 32'd0);
    tick();
    checkOutput("seq_addr2", ibus_addr, 32'h104);
    checkOutput("seq_valid2", 32'(inst_valid), 32'd1);
    checkOutput("seq_pc2", inst_pc, 32'h100);
    checkOutput("seq_data2", inst_data, 32'hFFFF_FEFF);
    tick();
    checkOutput("seq_addr3", ibus_addr, 32'h108);
    checkOutput("seq_pc3", inst_pc, 32'h104);
    checkOutput("seq_data3", inst_data, 32'hFFFF_FEFB);
    checkOutput("seq_level3", 32'(level), 32'd1);

    $display("[TB] fill FIFO with core stalled");
    rst_n = 1'b0;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    done_base = done_count;
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("full_level", 32'(level), 32'd4);
    checkOutput("full_bstart", 32'(ibus_bstart), 32'd0);
    checkOutput("full_addr", ibus_addr, 32'h110);
    repeat (2) tick();
    checkOutput("full_txns", 32'(done_count - done_base), 32'd4);
    checkOutput("full_bstart_hold", 32'(ibus_bstart), 32'd0);
    checkOutput("full_head_pc", inst_pc, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("pop_level", 32'(level), 32'd3);
    checkOutput("pop_head_pc", inst_pc, 32'h104);
    tick();
    checkOutput("refetch_bstart", 32'(ibus_bstart), 32'd1);
    checkOutput("refetch_addr", ibus_addr, 32'h110);

    $display("[TB] redirect while busy, delayed completion");
    rst_n = 1'b0;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("pre_redir_level", 32'(level), 32'd2);
    checkOutput("pre_redir_addr", ibus_addr, 32'h108);
    applyStimulus(1'b1, 32'h2002, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_valid", 32'(inst_valid), 32'd0);
    checkOutput("drain_addr", ibus_addr, 32'h108);
    checkOutput("drain_bstart", 32'(ibus_bstart), 32'd1);
    repeat (2) tick();
    checkOutput("drain_addr_hold", ibus_addr, 32'h108);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checkOutput("post_drain_addr", ibus_addr, 32'h2000);
    checkOutput("post_drain_bstart", 32'(ibus_bstart), 32'd1);
    checkOutput("post_drain_level", 32'(level), 32'd0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checkOutput("tgt_level", 32'(level), 32'd1);
    checkOutput("tgt_pc", inst_pc, 32'h2000);
    checkOutput("tgt_data", inst_data, 32'hFFFF_DFFF);
    checkOutput("tgt_addr", ibus_addr, 32'h2004);

    $display("[TB] redirect coincident with completion");
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("coin_addr", ibus_addr, 32'h3000);
    checkOutput("coin_bstart", 32'(ibus_bstart), 32'd1);
    checkOutput("coin_level", 32'(level), 32'd0);
    checkOutput("coin_valid", 32'(inst_valid), 32'd0);

    $display("[TB] two redirects during one drain");
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("dd_addr_hold", ibus_addr, 32'h3000);
    tick();
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    man_done = 1'b0;
    checkOutput("dd_addr", ibus_addr, 32'h800);
    checkOutput("dd_bstart", 32'(ibus_bstart), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("dd_last_done", last_done_addr, 32'h800);
    checkOutput("dd_next_addr", ibus_addr, 32'h804);
    checkOutput("dd_head_pc", inst_pc, 32'h800);

    $display("[TB] asynchronous reset mid-transaction");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    auto_done = 1'b0;
    checkOutput("ar_pre_level", 32'(level), 32'd2);
    checkOutput("ar_pre_bstart", 32'(ibus_bstart), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_bstart", 32'(ibus_bstart), 32'd0);
    checkOutput("ar_valid", 32'(inst_valid), 32'd0);
    checkOutput("ar_level", 32'(level), 32'd0);
    checkOutput("ar_addr", ibus_addr, 32'h100);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("ar_restart_addr", ibus_addr, 32'h100);
    checkOutput("ar_restart_bstart", 32'(ibus_bstart), 32'd1);
    tick();
    checkOutput("ar_restart_pc", inst_pc, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
